// File: rtl/fft_pkg.sv
// Shared FFT datapath types: sample width, complex sample, emission order.
package fft_pkg;

  localparam int SIZE_DATA = 16;

  typedef struct packed {
    logic [SIZE_DATA-1:0] i;
    logic [SIZE_DATA-1:0] q;
  } cplx_t;

  localparam logic ORDER_NATURAL = 1'b0;
  localparam logic ORDER_BITREV  = 1'b1;

  function automatic logic [1:0] bitrev2(
    input logic [1:0] x
  );
    return {x[0], x[1]};
  endfunction

endpackage

// File: rtl/fft4_out_serializer_if.sv
// Butterfly-block input bus plus valid/ready sample output bus.
interface fft4_out_serializer_if #(
  parameter int SIZE_DATA = fft_pkg::SIZE_DATA
);

  logic                 i_valid;
  logic [SIZE_DATA-1:0] i_data0_in_i;
  logic [SIZE_DATA-1:0] i_data0_in_q;
  logic [SIZE_DATA-1:0] i_data1_in_i;
  logic [SIZE_DATA-1:0] i_data1_in_q;
  logic [SIZE_DATA-1:0] i_data2_in_i;
  logic [SIZE_DATA-1:0] i_data2_in_q;
  logic [SIZE_DATA-1:0] i_data3_in_i;
  logic [SIZE_DATA-1:0] i_data3_in_q;
  logic                 o_in_ready;
  logic [SIZE_DATA-1:0] o_data_out_i;
  logic [SIZE_DATA-1:0] o_data_out_q;
  logic [1:0]           o_index;
  logic                 o_last;
  logic                 o_valid;
  logic                 i_ready;
  logic                 o_overflow;

  modport slave (
    input  i_valid,
    input  i_data0_in_i, i_data0_in_q,
    input  i_data1_in_i, i_data1_in_q,
    input  i_data2_in_i, i_data2_in_q,
    input  i_data3_in_i, i_data3_in_q,
    input  i_ready,
    output o_in_ready,
    output o_data_out_i, o_data_out_q,
    output o_index, o_last, o_valid,
    output o_overflow
  );

  modport master (
    output i_valid,
    output i_data0_in_i, i_data0_in_q,
    output i_data1_in_i, i_data1_in_q,
    output i_data2_in_i, i_data2_in_q,
    output i_data3_in_i, i_data3_in_q,
    output i_ready,
    input  o_in_ready,
    input  o_data_out_i, o_data_out_q,
    input  o_index, o_last, o_valid,
    input  o_overflow
  );

endinterface

// File: rtl/fft4_out_serializer.sv
// Two-slot ping-pong serializer for 4-point FFT blocks.
// FFT4_SER_OVF_FLAG_EN enables the sticky overflow flag and drop counter.
module fft4_out_serializer
  import fft_pkg::*;
#(
  parameter int    SIZE_DATA = fft_pkg::SIZE_DATA,
  parameter string OUT_ORDER = "natural"
) (
  input logic                    i_clk,
  input logic                    i_rst_n,
  fft4_out_serializer_if.slave   bus
);

  typedef struct packed {
    logic [SIZE_DATA-1:0] i;
    logic [SIZE_DATA-1:0] q;
  } smp_t;

  localparam logic ORDER =
    (OUT_ORDER == "bitrev") ? ORDER_BITREV
                            : ORDER_NATURAL;

  smp_t       slot [2][4];
  smp_t       din  [4];
  smp_t       cur;
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] cnt;
  logic [1:0] idx;
  logic [1:0] sel;
  logic       valid;
  logic       wr;
  logic       drop;
  logic       xfer;
  logic       done;

  assign din[0] = {bus.i_data0_in_i, bus.i_data0_in_q};
  assign din[1] = {bus.i_data1_in_i, bus.i_data1_in_q};
  assign din[2] = {bus.i_data2_in_i, bus.i_data2_in_q};
  assign din[3] = {bus.i_data3_in_i, bus.i_data3_in_q};

  assign valid = (cnt != 2'd0);
  assign wr    = bus.i_valid && (cnt != 2'd2);
  assign drop  = bus.i_valid && (cnt == 2'd2);
  assign xfer  = valid && bus.i_ready;
  assign done  = xfer && (idx == 2'd3);

  assign sel = (ORDER == ORDER_BITREV) ? bitrev2(idx) : idx;
  assign cur = slot[rd_ptr][sel];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < 2; s++)
        for (int k = 0; k < 4; k++)
          slot[s][k] <= '0;
    end else if (wr) begin
      for (int k = 0; k < 4; k++)
        slot[wr_ptr][k] <= din[k];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
      idx    <= 2'd0;
    end else begin
      if (wr)   wr_ptr <= ~wr_ptr;
      if (done) rd_ptr <= ~rd_ptr;
      if (xfer) idx    <= idx + 2'd1;
      cnt <= cnt + {1'b0, wr} - {1'b0, done};
    end
  end

`ifdef FFT4_SER_OVF_FLAG_EN
  logic [7:0] r_drop_cnt;

  // Counter is nonzero from the first drop on, so it doubles as the flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_drop_cnt <= 8'd0;
    else if (drop && (r_drop_cnt != 8'hff))
      r_drop_cnt <= r_drop_cnt + 8'd1;
  end

  assign bus.o_overflow = (r_drop_cnt != 8'd0);
`else
  logic unused_drop;
  assign unused_drop    = drop;
  assign bus.o_overflow = 1'b0;
`endif

  assign bus.o_in_ready   = (cnt != 2'd2);
  assign bus.o_valid      = valid;
  assign bus.o_index      = sel;
  assign bus.o_last       = (idx == 2'd3);
  assign bus.o_data_out_i = cur.i;
  assign bus.o_data_out_q = cur.q;

endmodule

// File: tb/tb_fft4_out_serializer.sv
// Bench: natural and bitrev instances driven together, checked against a
// block-queue reference model.
module tb_fft4_out_serializer;
  import fft_pkg::*;

  typedef struct {
    logic [15:0] i;
    logic [15:0] q;
    logic [1:0]  idx;
    logic        last;
  } exp_t;

  logic clk;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  bit          v_in;
  bit          r_in;
  logic [15:0] bi [4];
  logic [15:0] bq [4];

  exp_t qn [$];
  exp_t qb [$];
  bit   exp_ovf;

  fft4_out_serializer_if #(.SIZE_DATA(16)) bus_n ();
  fft4_out_serializer_if #(.SIZE_DATA(16)) bus_b ();

  fft4_out_serializer #(
    .SIZE_DATA(16),
    .OUT_ORDER("natural")
  ) dut_n (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus_n.slave)
  );

  fft4_out_serializer #(
    .SIZE_DATA(16),
    .OUT_ORDER("bitrev")
  ) dut_b (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus_n.i_valid      = v_in;
    bus_n.i_ready      = r_in;
    bus_n.i_data0_in_i = bi[0];
    bus_n.i_data0_in_q = bq[0];
    bus_n.i_data1_in_i = bi[1];
    bus_n.i_data1_in_q = bq[1];
    bus_n.i_data2_in_i = bi[2];
    bus_n.i_data2_in_q = bq[2];
    bus_n.i_data3_in_i = bi[3];
    bus_n.i_data3_in_q = bq[3];
    bus_b.i_valid      = v_in;
    bus_b.i_ready      = r_in;
    bus_b.i_data0_in_i = bi[0];
    bus_b.i_data0_in_q = bq[0];
    bus_b.i_data1_in_i = bi[1];
    bus_b.i_data1_in_q = bq[1];
    bus_b.i_data2_in_i = bi[2];
    bus_b.i_data2_in_q = bq[2];
    bus_b.i_data3_in_i = bi[3];
    bus_b.i_data3_in_q = bq[3];
  endtask

  task automatic chk_out(
    input string       nm,
    input logic        ov,
    input logic [15:0] di,
    input logic [15:0] dq,
    input logic [1:0]  ix,
    input logic        la,
    input logic        ir,
    input logic        of,
    input bit          ev,
    input exp_t        e,
    input bit          eir
  );
    chk({nm, ".valid"}, 32'(ov), 32'(ev));
    chk({nm, ".in_ready"}, 32'(ir), 32'(eir));
    chk({nm, ".overflow"}, 32'(of), 32'(exp_ovf));
    if (ev) begin
      chk({nm, ".data_i"}, 32'(di), 32'(e.i));
      chk({nm, ".data_q"}, 32'(dq), 32'(e.q));
      chk({nm, ".index"}, 32'(ix), 32'(e.idx));
      chk({nm, ".last"}, 32'(la), 32'(e.last));
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, ".rst_valid_n"}, 32'(bus_n.o_valid), 0);
    chk({nm, ".rst_last_n"}, 32'(bus_n.o_last), 0);
    chk({nm, ".rst_index_n"}, 32'(bus_n.o_index), 0);
    chk({nm, ".rst_di_n"}, 32'(bus_n.o_data_out_i), 0);
    chk({nm, ".rst_dq_n"}, 32'(bus_n.o_data_out_q), 0);
    chk({nm, ".rst_inrdy_n"}, 32'(bus_n.o_in_ready), 1);
    chk({nm, ".rst_ovf_n"}, 32'(bus_n.o_overflow), 0);
    chk({nm, ".rst_valid_b"}, 32'(bus_b.o_valid), 0);
    chk({nm, ".rst_index_b"}, 32'(bus_b.o_index), 0);
    chk({nm, ".rst_di_b"}, 32'(bus_b.o_data_out_i), 0);
    chk({nm, ".rst_inrdy_b"}, 32'(bus_b.o_in_ready), 1);
  endtask

  task automatic model_push();
    int ord [4] = '{0, 2, 1, 3};
    for (int k = 0; k < 4; k++) begin
      qn.push_back('{bi[k], bq[k], 2'(k), k == 3});
      qb.push_back('{bi[ord[k]], bq[ord[k]],
                     2'(ord[k]), k == 3});
    end
  endtask

  task automatic cyc(input string nm);
    exp_t en;
    exp_t eb;
    int   occ;
    bit   ev;
    drive();
    #1;
    occ = (qn.size() + 3) / 4;
    ev  = qn.size() != 0;
    en  = ev ? qn[0] : '{16'h0, 16'h0, 2'h0, 1'b0};
    eb  = ev ? qb[0] : '{16'h0, 16'h0, 2'h0, 1'b0};
    chk_out({nm, ".n"}, bus_n.o_valid, bus_n.o_data_out_i,
            bus_n.o_data_out_q, bus_n.o_index, bus_n.o_last,
            bus_n.o_in_ready, bus_n.o_overflow, ev, en, occ < 2);
    chk_out({nm, ".b"}, bus_b.o_valid, bus_b.o_data_out_i,
            bus_b.o_data_out_q, bus_b.o_index, bus_b.o_last,
            bus_b.o_in_ready, bus_b.o_overflow, ev, eb, occ < 2);
    @(posedge clk);
    if (ev && r_in) begin
      void'(qn.pop_front());
      void'(qb.pop_front());
    end
    if (v_in) begin
      if (occ < 2) model_push();
`ifdef FFT4_SER_OVF_FLAG_EN
      else exp_ovf = 1'b1;
`endif
    end
    #1;
  endtask

  task automatic rnd_blk();
    for (int k = 0; k < 4; k++) begin
      bi[k] = 16'($urandom);
      bq[k] = 16'($urandom);
    end
  endtask

  task automatic seq_blk(input int base);
    for (int k = 0; k < 4; k++) begin
      bi[k] = 16'(base + k + 1);
      bq[k] = 16'(base + k + 1);
    end
  endtask

  task automatic model_clear();
    qn.delete();
    qb.delete();
    exp_ovf = 1'b0;
  endtask

  initial begin
    bit sent;
    rst_n = 1'b0;
    v_in  = 1'b0;
    r_in  = 1'b0;
    exp_ovf = 1'b0;
    seq_blk(0);
    drive();
    #12;
    chk_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single block, natural and bitrev orders
    seq_blk(0);
    v_in = 1'b1;
    r_in = 1'b1;
    cyc("t1");
    v_in = 1'b0;
    for (int c = 0; c < 6; c++) cyc("t1");

    // two accepted, third dropped while stalled
    r_in = 1'b0;
    for (int b = 0; b < 3; b++) begin
      seq_blk(16 * (b + 1));
      v_in = 1'b1;
      cyc("t3");
    end
    v_in = 1'b0;
    for (int c = 0; c < 3; c++) cyc("t3");
    r_in = 1'b1;
    for (int c = 0; c < 10; c++) cyc("t3");

    // ready toggling
    rnd_blk();
    v_in = 1'b1;
    r_in = 1'b0;
    cyc("t4");
    v_in = 1'b0;
    for (int c = 0; c < 10; c++) begin
      r_in = (c % 2) == 0;
      cyc("t4");
    end

    // new block on the final transfer
    rst_n = 1'b0;
    #1;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rnd_blk();
    v_in = 1'b1;
    r_in = 1'b1;
    cyc("t5");
    sent = 1'b0;
    for (int c = 0; c < 10; c++) begin
      v_in = (qn.size() == 1) && !sent;
      if (v_in) begin
        rnd_blk();
        sent = 1'b1;
      end
      cyc("t5");
    end
    chk("t5.sent", 32'(sent), 1);

    // async reset mid-block
    rnd_blk();
    v_in = 1'b1;
    cyc("t6");
    v_in = 1'b0;
    cyc("t6");
    cyc("t6");
    rst_n = 1'b0;
    #1;
    chk_reset("t6");
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) cyc("t6");

    // random traffic
    for (int c = 0; c < 300; c++) begin
      v_in = ($urandom_range(0, 2) == 0);
      r_in = ($urandom_range(0, 3) != 0);
      if (v_in) rnd_blk();
      cyc("rnd");
    end
    v_in = 1'b0;
    r_in = 1'b1;
    for (int c = 0; c < 10; c++) cyc("drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
